// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the SDRAM port arbiter and its neighbours.
//   arb_state_e      : arbiter FSM states
//   SDRAM_ADDR_WIDTH : default flat {bank,row,col} address width (2+11+8)
//   SDRAM_DATA_WIDTH : default SDRAM data width
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WDATA,
        RDATA,
        DONE
    } arb_state_e;

    localparam int SDRAM_ADDR_WIDTH = 21;
    localparam int SDRAM_DATA_WIDTH = 32;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Picks the first set bit of req at or
// above ptr, wrapping around past N-1 back to 0.
//   req : request vector
//   ptr : highest-priority position this round (must be < N)
//   gnt : one-hot winner, all zero when nothing requests
//   idx : encoded winner index
//   vld : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int i = 0; i < N; i++) begin
            // Rotate the search start to ptr; a single subtraction suffices
            // because ptr < N and i < N.
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!vld && req[j]) begin
                vld    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
// Round-robin arbiter sharing one SDRAM controller between NUM_PORTS
// requesters. One port is granted per burst; its command and write data are
// muxed to the controller and controller strobes are steered back to it only.
// The data path is purely combinational (no added latency).
//   i_clk, i_rst          : clock, synchronous active-high reset
//   p_req/p_rwn/p_addr    : per-port command (addr/wdata packed per port)
//   p_wdata               : per-port write data
//   p_ack/p_wreq/p_rvalid : per-port command-accepted / write-beat / read-beat
//   p_rdata               : read data broadcast to all ports
//   p_done                : per-port end-of-burst (or abort) pulse
//   o_grant               : registered one-hot owner, zero when idle
//   o_timeout             : sticky watchdog abort flag
//   c_*                   : controller-side command/data interface
// ---------------------------------------------------------------------------
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SDRAM_DATA_WIDTH,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_PORTS-1:0]             p_req,
    input  logic [NUM_PORTS-1:0]             p_rwn,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wdata,
    output logic [NUM_PORTS-1:0]             p_ack,
    output logic [NUM_PORTS-1:0]             p_wreq,
    output logic [NUM_PORTS-1:0]             p_rvalid,
    output logic [DATA_WIDTH-1:0]            p_rdata,
    output logic [NUM_PORTS-1:0]             p_done,
    output logic [NUM_PORTS-1:0]             o_grant,
    output logic                             o_timeout,
    input  logic                             c_init_done,
    input  logic                             c_ack,
    input  logic                             c_data_req,
    input  logic                             c_data_valid,
    input  logic [DATA_WIDTH-1:0]            c_rdata,
    output logic                             c_adv,
    output logic                             c_rwn,
    output logic [ADDR_WIDTH-1:0]            c_addr,
    output logic [DATA_WIDTH-1:0]            c_wdata
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    arb_state_e           state_q;
    logic [NUM_PORTS-1:0] grant_q;
    logic [IW-1:0]        gidx_q;
    logic [IW-1:0]        rr_ptr_q;
    logic                 rwn_q;
    logic                 timeout_q;
    logic [BW-1:0]        beat_q;
    logic [WW-1:0]        wd_q;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic                 beat_fire;

    rr_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_rr_pick (
        .req (p_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Only strobes matching the active data direction count as beats.
    assign beat_fire = ((state_q == WDATA) && c_data_req) ||
                       ((state_q == RDATA) && c_data_valid);

    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            rwn_q     <= 1'b0;
            timeout_q <= 1'b0;
            beat_q    <= '0;
            wd_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (c_init_done && pick_vld) begin
                        state_q <= ISSUE;
                        grant_q <= pick_gnt;
                        gidx_q  <= pick_idx;
                        rwn_q   <= p_rwn[pick_idx];
                    end
                end
                ISSUE: begin
                    if (c_ack) begin
                        state_q <= rwn_q ? RDATA : WDATA;
                        beat_q  <= '0;
                        wd_q    <= '0;
                    end
                end
                WDATA, RDATA: begin
                    // A beat takes priority over a watchdog expiry in the
                    // same cycle; the watchdog restarts on every beat.
                    if (beat_fire) begin
                        wd_q   <= '0;
                        beat_q <= beat_q + BW'(1);
                        if (beat_q == BW'(BURST_LEN - 1)) begin
                            state_q <= DONE;
                        end
                    end else if (wd_q == WW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                DONE: begin
                    rr_ptr_q <= (gidx_q == IW'(NUM_PORTS - 1)) ? '0 : gidx_q + IW'(1);
                    grant_q  <= '0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Command/data muxing and strobe steering; everything is zero outside
    // the state that owns it, so stray controller strobes never leak out.
    always_comb begin
        p_ack    = '0;
        p_wreq   = '0;
        p_rvalid = '0;
        p_done   = '0;
        p_rdata  = '0;
        c_adv    = 1'b0;
        c_rwn    = 1'b0;
        c_addr   = '0;
        c_wdata  = '0;
        case (state_q)
            ISSUE: begin
                c_adv         = 1'b1;
                c_rwn         = p_rwn[gidx_q];
                c_addr        = p_addr[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
                p_ack[gidx_q] = c_ack;
            end
            WDATA: begin
                p_wreq[gidx_q] = c_data_req;
                c_wdata        = p_wdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
            end
            RDATA: begin
                p_rvalid[gidx_q] = c_data_valid;
                p_rdata          = c_rdata;
            end
            DONE: begin
                p_done[gidx_q] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 21;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int TO = 16;

    localparam int K_ACK = 0;
    localparam int K_WB  = 1;
    localparam int K_RB  = 2;
    localparam int K_DN  = 3;

    logic              clk = 1'b0;
    logic              i_rst;
    logic [NP-1:0]     p_req, p_rwn;
    logic [NP*AW-1:0]  p_addr;
    logic [NP*DW-1:0]  p_wdata;
    logic [NP-1:0]     p_ack, p_wreq, p_rvalid, p_done, o_grant;
    logic [DW-1:0]     p_rdata;
    logic              o_timeout;
    logic              c_init_done, c_ack, c_data_req, c_data_valid;
    logic [DW-1:0]     c_rdata;
    logic              c_adv, c_rwn;
    logic [AW-1:0]     c_addr;
    logic [DW-1:0]     c_wdata;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .p_req        (p_req),
        .p_rwn        (p_rwn),
        .p_addr       (p_addr),
        .p_wdata      (p_wdata),
        .p_ack        (p_ack),
        .p_wreq       (p_wreq),
        .p_rvalid     (p_rvalid),
        .p_rdata      (p_rdata),
        .p_done       (p_done),
        .o_grant      (o_grant),
        .o_timeout    (o_timeout),
        .c_init_done  (c_init_done),
        .c_ack        (c_ack),
        .c_data_req   (c_data_req),
        .c_data_valid (c_data_valid),
        .c_rdata      (c_rdata),
        .c_adv        (c_adv),
        .c_rwn        (c_rwn),
        .c_addr       (c_addr),
        .c_wdata      (c_wdata)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct { int kind; int port; logic [31:0] val; } exp_t;
    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   end_req  = 1'b0;

    task automatic sb_event(input int kind, input logic [7:0] vec, input logic [31:0] val);
        exp_t e;
        logic [2:0]  oh;
        logic [47:0] a, r;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got kind=%0d vec=%b val=%h, required no event", kind, vec, val);
        end else begin
            e  = exp_q.pop_front();
            oh = 3'(1 << e.port);
            a  = {8'(kind), vec, val};
            r  = {8'(e.kind), {2'b00, oh, oh}, e.val};
            if (a !== r) begin
                n_errors++;
                $display("FAIL sb_event: got kind=%0d grant/strobe=%b val=%h, required kind=%0d grant/strobe=%b val=%h",
                         kind, vec, val, e.kind, {2'b00, oh, oh}, e.val);
            end
        end
    endtask

    // Monitor: event scoreboard at negedge+2, queued point checks at +4.
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            #2;
            if (p_ack != 0)    sb_event(K_ACK, {2'b00, o_grant, p_ack},    32'(c_addr));
            if (p_wreq != 0)   sb_event(K_WB,  {2'b00, o_grant, p_wreq},   c_wdata);
            if (p_rvalid != 0) sb_event(K_RB,  {2'b00, o_grant, p_rvalid}, p_rdata);
            if (p_done != 0)   sb_event(K_DN,  {2'b00, o_grant, p_done},   32'(o_timeout));
            #2;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_checks++;
                if (c.act !== c.exp) begin
                    n_errors++;
                    $display("FAIL %s: got %h, required %h", c.name, c.act, c.exp);
                end
            end
            if (end_req) begin
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_errors++;
                    $display("FAIL sb_drain: got %0d pending events, required 0", exp_q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus, requester and controller models
    // ------------------------------------------------------------------
    int          m_st, m_beat, m_limit;
    bit          m_rwn, m_spur;
    logic [31:0] m_rbase;
    logic [NP-1:0] last_ack, last_wreq;
    logic        last_adv, last_rwn;
    int          wptr [NP];
    bit          auto_drop;
    int          cyc, n_done, n_rv2, n_rvo, last_beat_cyc, done_cyc;

    function automatic logic [31:0] wdat(input int k, input int b);
        if (k == 1) return 32'h11111111 * 32'(b + 1);
        return 32'hC0DE0000 | 32'(k << 8) | 32'(b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic bfm_step();
        for (int k = 0; k < NP; k++) begin
            if (last_ack[k] && auto_drop) p_req[k] = 1'b0;
            if (last_wreq[k]) begin
                wptr[k]++;
                p_wdata[k*DW +: DW] = wdat(k, wptr[k]);
            end
        end
        c_ack        = 1'b0;
        c_data_req   = 1'b0;
        c_data_valid = 1'b0;
        c_rdata      = '0;
        if (i_rst) begin
            m_st = 0;
        end else if (m_st == 0) begin
            if (m_spur) begin
                c_data_req   = 1'b1;
                c_data_valid = 1'b1;
                c_rdata      = 32'hBADBAD00;
                m_spur       = 1'b0;
            end else if (last_adv) begin
                c_ack  = 1'b1;
                m_rwn  = last_rwn;
                m_beat = 0;
                m_st   = 1;
            end
        end else begin
            if (m_beat < m_limit) begin
                if (m_rwn) begin
                    c_data_valid = 1'b1;
                    c_rdata      = m_rbase + 32'(m_beat);
                end else begin
                    c_data_req = 1'b1;
                end
                m_beat++;
            end else begin
                m_st = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bfm_step();
        #3;
        cyc++;
        last_ack  = p_ack;
        last_wreq = p_wreq;
        last_adv  = c_adv;
        last_rwn  = c_rwn;
        if (p_done != 0) begin
            n_done++;
            done_cyc = cyc;
        end
        n_rv2 += int'(p_rvalid[2]);
        if (p_rvalid[1:0] != 0) n_rvo++;
        if (p_rvalid != 0) last_beat_cyc = cyc;
    endtask

    task automatic wait_dones(input string name, input int n, input int budget);
        int start;
        int t;
        start = n_done;
        t = 0;
        while ((n_done - start) < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, 32'(n_done - start), 32'(n));
    endtask

    task automatic start_req(input int k, input bit rwn, input logic [AW-1:0] a);
        p_req[k] = 1'b1;
        p_rwn[k] = rwn;
        p_addr[k*AW +: AW] = a;
        wptr[k] = 0;
        p_wdata[k*DW +: DW] = wdat(k, 0);
    endtask

    task automatic push_txn(input int k, input bit rwn, input logic [AW-1:0] a,
                            input int nb, input bit with_done, input bit tmo);
        exp_q.push_back('{kind: K_ACK, port: k, val: 32'(a)});
        for (int b = 0; b < nb; b++) begin
            if (rwn) exp_q.push_back('{kind: K_RB, port: k, val: 32'hDEAD0000 + 32'(b)});
            else     exp_q.push_back('{kind: K_WB, port: k, val: wdat(k, b)});
        end
        if (with_done) exp_q.push_back('{kind: K_DN, port: k, val: 32'(tmo)});
    endtask

    initial begin
        int adv_cnt;
        i_rst = 1'b1; p_req = '0; p_rwn = '0; p_addr = '0; p_wdata = '0;
        c_init_done = 1'b0; c_ack = 1'b0; c_data_req = 1'b0; c_data_valid = 1'b0; c_rdata = '0;
        m_st = 0; m_beat = 0; m_limit = BL; m_rwn = 1'b0; m_spur = 1'b0; m_rbase = 32'hDEAD0000;
        last_ack = '0; last_wreq = '0; last_adv = 1'b0; last_rwn = 1'b0;
        for (int k = 0; k < NP; k++) wptr[k] = 0;
        auto_drop = 1'b1;
        cyc = 0; n_done = 0; n_rv2 = 0; n_rvo = 0; last_beat_cyc = 0; done_cyc = 0;

        // Reset values
        repeat (3) tick();
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_timeout", 32'(o_timeout), 32'h0);
        chk("rst_adv", 32'(c_adv), 32'h0);
        chk("rst_strobes", 32'({p_ack, p_wreq, p_rvalid, p_done}), 32'h0);
        i_rst = 1'b0;

        // Init gating, then 1-cycle grant latency
        start_req(0, 1'b1, 21'h00100);
        adv_cnt = 0;
        repeat (100) begin
            tick();
            adv_cnt += int'(c_adv);
        end
        chk("init_gate_adv", 32'(adv_cnt), 32'h0);
        push_txn(0, 1'b1, 21'h00100, BL, 1'b1, 1'b0);
        c_init_done = 1'b1;
        tick();
        chk("init_adv", 32'(c_adv), 32'h1);
        chk("init_grant", 32'(o_grant), 32'h1);
        wait_dones("init_done", 1, 50);
        tick();
        chk("init_grant_clear", 32'(o_grant), 32'h0);

        // Simultaneous continuous requests from reset: order 0,1,2,0
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        auto_drop = 1'b0;
        start_req(0, 1'b1, 21'h00010);
        start_req(1, 1'b0, 21'h0A5F3);
        start_req(2, 1'b1, 21'h1FFFF);
        push_txn(0, 1'b1, 21'h00010, BL, 1'b1, 1'b0);
        push_txn(1, 1'b0, 21'h0A5F3, BL, 1'b1, 1'b0);
        push_txn(2, 1'b1, 21'h1FFFF, BL, 1'b1, 1'b0);
        push_txn(0, 1'b1, 21'h00010, BL, 1'b1, 1'b0);
        wait_dones("rr_three_done", 3, 200);
        p_req[2:1] = 2'b00;
        wait_dones("rr_fourth_done", 1, 100);
        p_req = '0;
        auto_drop = 1'b1;
        tick();

        // Stray controller strobes in IDLE are not forwarded
        m_spur = 1'b1;
        tick();
        chk("gate_idle_strobes", 32'({p_wreq, p_rvalid}), 32'h0);
        chk("gate_idle_rdata", p_rdata, 32'h0);

        // Write burst on port 1
        start_req(1, 1'b0, 21'h0A5F3);
        push_txn(1, 1'b0, 21'h0A5F3, BL, 1'b1, 1'b0);
        wait_dones("wr_done", 1, 50);
        tick();

        // Read burst on port 2
        n_rv2 = 0;
        n_rvo = 0;
        start_req(2, 1'b1, 21'h12345);
        push_txn(2, 1'b1, 21'h12345, BL, 1'b1, 1'b0);
        wait_dones("rd_done", 1, 50);
        chk("rd_rvalid2_cycles", 32'(n_rv2), 32'h4);
        chk("rd_rvalid_other", 32'(n_rvo), 32'h0);
        tick();

        // Watchdog: controller stalls after 2 beats
        m_limit = 2;
        start_req(0, 1'b1, 21'h00777);
        push_txn(0, 1'b1, 21'h00777, 2, 1'b1, 1'b1);
        wait_dones("wd_done", 1, 80);
        chk("wd_gap", 32'(done_cyc - last_beat_cyc), 32'd17);
        chk("wd_timeout", 32'(o_timeout), 32'h1);
        tick();
        chk("wd_grant_clear", 32'(o_grant), 32'h0);
        m_limit = BL;
        start_req(1, 1'b0, 21'h00ABC);
        push_txn(1, 1'b0, 21'h00ABC, BL, 1'b1, 1'b1);
        wait_dones("wd_next_done", 1, 50);
        tick();

        // Reset during beat 2 of a read
        n_rv2 = 0;
        start_req(2, 1'b1, 21'h15555);
        push_txn(2, 1'b1, 21'h15555, 2, 1'b0, 1'b0);
        begin
            int t;
            t = 0;
            while (n_rv2 < 2 && t < 50) begin
                tick();
                t++;
            end
        end
        chk("rstmid_beats_seen", 32'(n_rv2), 32'h2);
        i_rst = 1'b1;
        tick();
        chk("rstmid_grant", 32'(o_grant), 32'h0);
        chk("rstmid_timeout", 32'(o_timeout), 32'h0);
        chk("rstmid_adv_rwn", 32'({c_adv, c_rwn}), 32'h0);
        chk("rstmid_strobes", 32'({p_ack, p_wreq, p_rvalid, p_done}), 32'h0);
        chk("rstmid_caddr", 32'(c_addr), 32'h0);
        chk("rstmid_data", c_wdata | p_rdata, 32'h0);
        i_rst = 1'b0;
        p_req = '0;
        start_req(1, 1'b0, 21'h0A5F3);
        start_req(2, 1'b1, 21'h00042);
        push_txn(1, 1'b0, 21'h0A5F3, BL, 1'b1, 1'b0);
        push_txn(2, 1'b1, 21'h00042, BL, 1'b1, 1'b0);
        wait_dones("rstmid_after_done", 2, 100);
        tick();
        end_req = 1'b1;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares one `sdram_controller` between up to `NUM_PORTS` requesters (for example CPU instruction fetch, CPU data and DMA/video). It sits directly in front of the controller's `i_addr/i_adv/i_rwn/o_ack/o_data_req/o_data_valid` interface. It grants one port per burst, muxes that port's command and write data into the controller, and steers controller data strobes back to the granted port only.

## Interface
Parameters:
- `NUM_PORTS`, 3, number of requesters (2..8)
- `ADDR_WIDTH`, 21, flat `{bank,row,col}` address width (2+11+8)
- `DATA_WIDTH`, 32, SDRAM data width
- `BURST_LEN`, 4, data beats per granted transaction (1..8)
- `TIMEOUT`, 255, maximum cycles between consecutive beats before abort

Ports:
- `i_clk` in 1: sole clock. Reset is synchronous and active-high.
- `i_rst` in 1: synchronous reset, active high.
- `p_req` in NUM_PORTS: per-port request. Must be held until the matching `p_ack`.
- `p_rwn` in NUM_PORTS: 1 = read, 0 = write.
- `p_addr` in NUM_PORTS*ADDR_WIDTH: packed addresses, with port k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `p_wdata` in NUM_PORTS*DATA_WIDTH: packed write data.
- `p_ack` out NUM_PORTS: one-cycle command-accepted pulse to the granted port.
- `p_wreq` out NUM_PORTS: write-beat strobe. The port advances its data on the next cycle.
- `p_rvalid` out NUM_PORTS: read-beat valid.
- `p_rdata` out DATA_WIDTH: read data, broadcast to all ports.
- `p_done` out NUM_PORTS: one-cycle pulse after the last beat or after an abort.
- `o_grant` out NUM_PORTS: one-hot current owner. All zero when idle.
- `o_timeout` out 1: sticky abort flag, cleared only by reset.
- `c_init_done`, `c_ack`, `c_data_req`, `c_data_valid` in 1 each: from the controller.
- `c_rdata` in DATA_WIDTH: from the controller.
- `c_adv`, `c_rwn` out 1 each: to the controller.
- `c_addr` out ADDR_WIDTH: to the controller.
- `c_wdata` out DATA_WIDTH: to the controller.

## Operation
- **States:**
  - `IDLE`: no grant.
  - `ISSUE`: `c_adv` held high until `c_ack`.
  - `WDATA` or `RDATA`: counting beats.
  - `DONE`: one cycle, pulses `p_done`.
- **IDLE → ISSUE:** taken when `c_init_done` is high and any `p_req` is set.
  - Winner is the first requesting port at or after `rr_ptr`, searching upward with wrap-around.
  - `o_grant` is registered on this transition.
- **ISSUE:**
  - `c_adv=1`, with `c_addr` and `c_rwn` muxed from the granted port.
  - On `c_ack`: `p_ack[g]` follows `c_ack` combinationally, then the FSM goes to `WDATA` or `RDATA` per the latched `rwn`.
- **WDATA:**
  - `p_wreq[g] = c_data_req`.
  - `c_wdata = p_wdata[g]`, combinationally.
  - The beat counter increments on each `c_data_req`.
- **RDATA:**
  - `p_rvalid[g] = c_data_valid`.
  - `p_rdata = c_rdata`.
  - The beat counter increments on each `c_data_valid`.
- **Beat count:** the beat counter is `$clog2(BURST_LEN+1)` bits. Reaching `BURST_LEN` moves to `DONE`.
- **DONE:** `p_done[g]=1`, `rr_ptr ← (g+1) mod NUM_PORTS`, then the FSM goes to `IDLE` with `o_grant` cleared.
- **Watchdog:**
  - Counter resets on entry to a data state and on each beat.
  - If it reaches `TIMEOUT`, set `o_timeout` and go to `DONE`. This releases the grant and skips the remaining beats.
- **Strobe gating:** strobes from the controller outside a data state are ignored and never forwarded.
- **Late requests:** a port raising `p_req` mid-burst waits. A grant is never preempted.
- **Reset:** reset at any point forces `IDLE`, `rr_ptr=0`, and all outputs 0. In-flight transactions are lost and requesters must reissue.

## Timing
- Minimum grant latency is 1 cycle: `p_req` seen in `IDLE` at cycle N gives `c_adv` high at cycle N+1.
- No registered stage on the data path. Beat strobes and data pass through combinationally, with zero added latency.
- Minimum turnaround from the last beat to the next `c_adv` is 2 cycles (`DONE`, then `IDLE`).
- With `NUM_PORTS` ports continuously requesting, the grant order is 0,1,2,0,…. No port waits more than `NUM_PORTS-1` bursts.
- Reset values:
  - Registered: `o_grant=0`, `o_timeout=0`.
  - Combinational outputs, which are all 0 in `IDLE`: `c_adv`, `p_ack`, `p_wreq`, `p_rvalid`, `p_done`.

## Structure
- Shared package `sdram_arb_pkg` holds:
  - the state enum `{IDLE, ISSUE, WDATA, RDATA, DONE}`;
  - the default `ADDR_WIDTH`/`DATA_WIDTH` values, shared with the controller bench.
- One sub-module, `rr_pick`: combinational round-robin selector taking `req` and `ptr` and returning a one-hot `gnt` and an encoded index. It is reused by future bus arbiters.

## Test plan
1. **Init gating:** `c_init_done=0` with `p_req=3'b001` → no `c_adv` for 100 cycles. Raise `c_init_done` → `c_adv` high the next cycle, `o_grant=001`.
2. **Simultaneous requests:** `p_req=3'b111` held, `BURST_LEN=4` → grants 001, 010, 100, 001 in sequence. `p_done` pulses once per port after 4 beats each.
3. **Write burst:** port 1, addr `0x0A5F3`, `rwn=0`, data `0x11111111`..`0x44444444` → controller model receives those 4 words in order. `p_wreq` appears only on port 1.
4. **Read burst:** port 2 reads 4 beats; model returns `0xDEAD0000`..`0xDEAD0003`. `p_rvalid[2]` is high for exactly 4 cycles, `p_rvalid[0]` and `p_rvalid[1]` stay 0.
5. **Watchdog:** `TIMEOUT=16`, controller stalls after beat 2 → after 16 idle cycles `o_timeout=1`, `p_done` pulses and the grant clears. The next request is granted normally.
6. **Reset mid-burst:** assert `i_rst` during beat 2 of a read → the next cycle shows all outputs 0 and `rr_ptr=0`. After release with `p_req=3'b110`, port 1 is granted first.
